// File: rtl/tl_sensor_queue_if.sv
// Bundle of detector, controller-state and queue-status signals for tl_sensor_queue.
// The master drives the detectors and controller state; the slave reports the queue status.
interface tl_sensor_queue_if #(
   parameter int CNT_W = 4
);
   logic             car_a;
   logic             car_al;
   logic             car_b;
   logic             car_bl;
   logic [2:0]       q;
   logic             dep_tick;
   logic             clr_ovf;
   logic             Ta;
   logic             Tal;
   logic             Tb;
   logic             Tbl;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_al;
   logic [CNT_W-1:0] cnt_b;
   logic [CNT_W-1:0] cnt_bl;
   logic [3:0]       ovf;

   modport master (
      output car_a, car_al, car_b, car_bl, q, dep_tick, clr_ovf,
      input  Ta, Tal, Tb, Tbl, cnt_a, cnt_al, cnt_b, cnt_bl, ovf
   );

   modport slave (
      input  car_a, car_al, car_b, car_bl, q, dep_tick, clr_ovf,
      output Ta, Tal, Tb, Tbl, cnt_a, cnt_al, cnt_b, cnt_bl, ovf
   );
endinterface

// File: rtl/tl_sensor_queue.sv
// Four-lane vehicle queue counters feeding the left-turn light controller's Ta/Tal/Tb/Tbl inputs.
// Optional detector debounce is compiled in with TL_SENSOR_DEBOUNCE_EN.
module tl_sensor_queue #(
   parameter int CNT_W  = 4,
   parameter int DB_CYC = 3
) (
   input logic               clk,
   input logic               reset,
   tl_sensor_queue_if.slave  bus
);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // Lane index order everywhere: 0 = A, 1 = A-left, 2 = B, 3 = B-left
   logic [3:0]       car_s;
   logic [3:0]       s1_r;
   logic [3:0]       prev_r;
   logic [3:0]       f_s;
   logic [3:0]       arr_s;
   logic [3:0]       dep_s;
   logic [3:0]       ovf_r;
   logic [3:0]       ovf_set_s;
   logic [3:0]       ovf_nxt_s;
   logic [CNT_W-1:0] cnt_r     [4];
   logic [CNT_W-1:0] cnt_nxt_s [4];

   assign car_s = {bus.car_bl, bus.car_b, bus.car_al, bus.car_a};

`ifdef TL_SENSOR_DEBOUNCE_EN
   localparam int DB_W = $clog2(DB_CYC + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

   logic [DB_W-1:0] db_cnt_r [4];
   logic [3:0]      f_r;

   // Debounce: accept a new level only after DB_CYC consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         f_r <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            db_cnt_r[i] <= {DB_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (s1_r[i] == f_r[i]) begin
               db_cnt_r[i] <= {DB_W{1'b0}};
            end else if (db_cnt_r[i] == DB_LAST) begin
               f_r[i]      <= s1_r[i];
               db_cnt_r[i] <= {DB_W{1'b0}};
            end else begin
               db_cnt_r[i] <= db_cnt_r[i] + {{(DB_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   assign f_s = f_r;
`else
   assign f_s = s1_r;
`endif

   // Arrival/departure decode and saturating counter next-state
   always_comb begin
      arr_s     = f_s & ~prev_r;
      dep_s     = 4'b0000;
      ovf_set_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         cnt_nxt_s[i] = cnt_r[i];
         // Green codes are even: lane i is green at {i, 0}
         dep_s[i] = bus.dep_tick & (bus.q == 3'(2 * i)) & (cnt_r[i] != CNT_ZERO);
         case ({arr_s[i], dep_s[i]})
            2'b10: begin
               if (cnt_r[i] == CNT_MAX) begin
                  ovf_set_s[i] = 1'b1;
               end else begin
                  cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
               end
            end
            2'b01:   cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
            default: cnt_nxt_s[i] = cnt_r[i];
         endcase
      end
      ovf_nxt_s = (bus.clr_ovf ? 4'b0000 : ovf_r) | ovf_set_s;
   end

   // Sample, edge-history, count and overflow registers
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_r   <= 4'b0000;
         prev_r <= 4'b0000;
         ovf_r  <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
      end else begin
         s1_r   <= car_s;
         prev_r <= f_s;
         ovf_r  <= ovf_nxt_s;
         for (int i = 0; i < 4; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
      end
   end

   assign bus.cnt_a  = cnt_r[0];
   assign bus.cnt_al = cnt_r[1];
   assign bus.cnt_b  = cnt_r[2];
   assign bus.cnt_bl = cnt_r[3];
   assign bus.Ta     = (cnt_r[0] != CNT_ZERO);
   assign bus.Tal    = (cnt_r[1] != CNT_ZERO);
   assign bus.Tb     = (cnt_r[2] != CNT_ZERO);
   assign bus.Tbl    = (cnt_r[3] != CNT_ZERO);
   assign bus.ovf    = ovf_r;
endmodule

// File: tb/tb_tl_sensor_queue.sv
// Scoreboard bench for tl_sensor_queue: a lane-level queue model predicts every edge,
// a monitor compares counts, traffic flags and overflow flags one time unit after each edge.
module tb_tl_sensor_queue;
   localparam int CNT_W  = 4;
   localparam int DB_CYC = 3;
   localparam int MAXC   = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   tl_sensor_queue_if #(.CNT_W(CNT_W)) bus ();

   tl_sensor_queue #(.CNT_W(CNT_W), .DB_CYC(DB_CYC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [3:0][7:0] cnt;
      logic [3:0]      ovf;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference model: queue lengths plus the detector history needed to spot arrivals
   int       m_cnt [4];
   int       m_run [4];
   bit [3:0] m_ovf;
   bit [3:0] m_last;
   bit [3:0] m_lold;
   bit [3:0] m_acc;

   task automatic chk(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   task automatic step(input logic [3:0] car, input logic [2:0] qv,
                       input logic dep, input logic clr, input logic rst);
      exp_t e;
      bit [3:0] set;
      bit lv;
      bit arr;
      bit dp;
      int nv;
      bus.car_a    = car[0];
      bus.car_al   = car[1];
      bus.car_b    = car[2];
      bus.car_bl   = car[3];
      bus.q        = qv;
      bus.dep_tick = dep;
      bus.clr_ovf  = clr;
      reset        = rst;
      set          = 4'b0000;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_run[i] = 0;
         end
         m_ovf  = 4'b0000;
         m_last = 4'b0000;
         m_lold = 4'b0000;
         m_acc  = 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
`ifdef TL_SENSOR_DEBOUNCE_EN
            lv = m_acc[i];
            if (m_last[i] != m_acc[i]) begin
               m_run[i]++;
               if (m_run[i] == DB_CYC) begin
                  m_acc[i] = m_last[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
`else
            lv = m_last[i];
`endif
            arr       = lv && !m_lold[i];
            m_lold[i] = lv;
            dp = dep && (qv[0] == 1'b0) && (int'(qv[2:1]) == i) && (m_cnt[i] > 0);
            nv = m_cnt[i] + int'(arr) - int'(dp);
            if (nv > MAXC) begin
               nv     = MAXC;
               set[i] = 1'b1;
            end
            m_cnt[i] = nv;
         end
         m_ovf  = (clr ? 4'b0000 : m_ovf) | set;
         m_last = car;
      end
      for (int i = 0; i < 4; i++) e.cnt[i] = 8'(m_cnt[i]);
      e.ovf = m_ovf;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic pulse(input logic [3:0] lanes, input int hi, input int lo,
                        input logic [2:0] qv, input logic dep, input logic clr);
      for (int k = 0; k < hi; k++) step(lanes, qv, dep, clr, 1'b0);
      for (int k = 0; k < lo; k++) step(4'b0000, qv, dep, clr, 1'b0);
   endtask

   // Monitor: one expected entry per clock edge, checked just after that edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cnt_a",  int'(bus.cnt_a),  int'(e.cnt[0]));
            chk("cnt_al", int'(bus.cnt_al), int'(e.cnt[1]));
            chk("cnt_b",  int'(bus.cnt_b),  int'(e.cnt[2]));
            chk("cnt_bl", int'(bus.cnt_bl), int'(e.cnt[3]));
            chk("Ta",     int'(bus.Ta),     int'(e.cnt[0] != 8'd0));
            chk("Tal",    int'(bus.Tal),    int'(e.cnt[1] != 8'd0));
            chk("Tb",     int'(bus.Tb),     int'(e.cnt[2] != 8'd0));
            chk("Tbl",    int'(bus.Tbl),    int'(e.cnt[3] != 8'd0));
            chk("ovf",    int'(bus.ovf),    int'(e.ovf));
         end
      end
   end

   initial begin
      logic [3:0] car_r;
      int wait_cyc;
      // Reset with car_a held high across release: exactly one arrival
      step(4'b0001, 3'b000, 1'b0, 1'b0, 1'b1);
      step(4'b0001, 3'b000, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) step(4'b0001, 3'b000, 1'b0, 1'b0, 1'b0);
      step(4'b0000, 3'b000, 1'b0, 1'b0, 1'b0);
      // Three arrivals on B through while A is green
      for (int k = 0; k < 3; k++) pulse(4'b0100, 4, 4, 3'b000, 1'b0, 1'b0);
      // Two A-left arrivals, then drain with A-left green, then ticks in yellow
      for (int k = 0; k < 2; k++) pulse(4'b0010, 4, 4, 3'b000, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(4'b0000, 3'b010, 1'b1, 1'b0, 1'b0);
         step(4'b0000, 3'b010, 1'b0, 1'b0, 1'b0);
      end
      pulse(4'b0010, 4, 4, 3'b000, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step(4'b0000, 3'b011, 1'b1, 1'b0, 1'b0);
      // Build cnt_a up, then arrivals against continuous departures
      for (int k = 0; k < 4; k++) pulse(4'b0001, 4, 4, 3'b000, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) pulse(4'b0001, 4, 4, 3'b000, 1'b1, 1'b0);
      // Saturation of B-left, clear, then arrival with clear in the same cycles
      for (int k = 0; k < 17; k++) pulse(4'b1000, 4, 4, 3'b100, 1'b0, 1'b0);
      step(4'b0000, 3'b100, 1'b0, 1'b1, 1'b0);
      step(4'b0000, 3'b100, 1'b0, 1'b0, 1'b0);
      pulse(4'b1000, 4, 4, 3'b100, 1'b0, 1'b1);
      // Saturated count with a departure on the arrival edge
      pulse(4'b1000, 4, 4, 3'b110, 1'b1, 1'b1);
      // Short glitch on car_a
      pulse(4'b0001, 2, 6, 3'b001, 1'b0, 1'b0);
      pulse(4'b0001, 1, 6, 3'b001, 1'b0, 1'b0);
      // Randomized traffic
      car_r = 4'b0000;
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 3) == 0) car_r[i] = ~car_r[i];
         end
         step(car_r, 3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 49) == 0), ($urandom_range(0, 399) == 0));
      end
      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         #2;
         wait_cyc++;
      end
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
